// File: rtl/demux_pkg.sv
// Shared types and constants for the round-robin demux dispatcher.
package demux_pkg;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 8;

   typedef logic [1:0] ch_idx_t;

   typedef enum logic {
      IDLE = 1'b0,
      FULL = 1'b1
   } state_t;

endpackage

// File: rtl/demux_rr_dispatcher_rr_pick.sv
// Round-robin channel picker: the first enabled channel at or after rr_ptr_i, modulo 4.
module rr_pick
   import demux_pkg::*;
(
   input  logic [1:0]        rr_ptr_i,
   input  logic [NUM_CH-1:0] en_mask_i,
   output logic [1:0]        pick_o,
   output logic              found_o
);

   logic [1:0] idx;

   // Walk the offsets from farthest to nearest so the nearest enabled channel wins.
   always_comb begin
      pick_o  = rr_ptr_i;
      found_o = 1'b0;
      idx     = rr_ptr_i;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = rr_ptr_i + ch_idx_t'(k);
         if (en_mask_i[idx]) begin
            pick_o  = idx;
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// One-word holding register that routes each accepted word to a round-robin chosen
// enabled channel, with per-channel delivered-word counters.
module demux_rr_dispatcher
   import demux_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NUM_CH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic [3:0]        en_mask,
   output logic [3:0]        out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic [3:0]        out_ready,
   output logic [1:0]        sel,
   input  logic [1:0]        cnt_sel,
   output logic [7:0]        cnt_out,
   input  logic              cnt_clr
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [1:0]        sel_q, sel_d;
   logic [1:0]        rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];

   logic [1:0] pick;
   logic       found;
   logic       deliver;
   logic       accept;

   rr_pick u_rr_pick (
      .rr_ptr_i  (rr_ptr_q),
      .en_mask_i (en_mask),
      .pick_o    (pick),
      .found_o   (found)
   );

   // in_ready is gated by rst_n so it drops immediately, without waiting for a clock.
   assign deliver  = (state_q == FULL) && out_ready[sel_q];
   assign in_ready = rst_n && found && ((state_q == IDLE) || deliver);
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid = '0;
      if (state_q == FULL) begin
         out_valid[sel_q] = 1'b1;
      end
   end

   assign out_data = data_q;
   assign sel      = sel_q;
   assign cnt_out  = cnt_q[cnt_sel];

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      sel_d    = sel_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         IDLE: if (accept) state_d = FULL;
         FULL: if (deliver && !accept) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (accept) begin
         data_d   = in_data;
         sel_d    = pick;
         rr_ptr_d = pick + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         data_q   <= '0;
         sel_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         sel_q    <= sel_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Clear beats a same-cycle delivery increment.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
      assign cnt_d[gi] = cnt_clr ? '0 :
                         (deliver && (sel_q == ch_idx_t'(gi))) ? cnt_q[gi] + CNT_ONE :
                         cnt_q[gi];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Directed bench for demux_rr_dispatcher: scoreboard of accepted words checked on delivery.
module tb_demux_rr_dispatcher;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [3:0] en_mask;
   logic [3:0] out_valid;
   logic [7:0] out_data;
   logic [3:0] out_ready;
   logic [1:0] sel;
   logic [1:0] cnt_sel;
   logic [7:0] cnt_out;
   logic       cnt_clr;

   always #10 clk = ~clk;

   demux_rr_dispatcher #(.DATA_W(8), .NUM_CH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .en_mask   (en_mask),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .sel       (sel),
      .cnt_sel   (cnt_sel),
      .cnt_out   (cnt_out),
      .cnt_clr   (cnt_clr)
   );

   typedef struct {
      logic [1:0] ch;
      logic [7:0] data;
   } item_t;

   item_t      sb[$];
   int         dlog[$];
   int         exp_q[$];
   logic [1:0] m_ptr;
   logic [7:0] m_cnt [4];
   int         n_assert = 0;
   int         n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] ref_pick();
      logic [1:0] c;
      logic [1:0] r;
      r = m_ptr;
      for (int k = 3; k >= 0; k--) begin
         c = m_ptr + 2'(k);
         if (en_mask[c]) r = c;
      end
      return r;
   endfunction

   // Called just after a falling edge with inputs set; checks, updates the model, advances one cycle.
   task automatic tick();
      logic       full, dlv, exp_ready, acc;
      logic [3:0] exp_valid;
      item_t      hd, it;
      #1;
      if (sb.size() != 0) begin
         full = 1'b1;
         hd   = sb[0];
      end else begin
         full    = 1'b0;
         hd.ch   = 2'd0;
         hd.data = 8'd0;
      end
      dlv       = full && out_ready[hd.ch];
      exp_ready = rst_n && (en_mask != 4'b0000) && (!full || dlv);
      exp_valid = 4'b0000;
      if (full) exp_valid[hd.ch] = 1'b1;
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, exp_valid);
      if (full) begin
         chk("out_data", out_data, hd.data);
         chk("sel", sel, hd.ch);
      end
      acc = in_valid && exp_ready;
      if (dlv) begin
         it = sb.pop_front();
         dlog.push_back(int'(it.ch));
         if (!cnt_clr) m_cnt[it.ch]++;
      end
      if (cnt_clr) for (int c = 0; c < 4; c++) m_cnt[c] = 8'd0;
      if (acc) begin
         it.ch   = ref_pick();
         it.data = in_data;
         sb.push_back(it);
         m_ptr = it.ch + 2'd1;
      end
      @(negedge clk);
   endtask

   task automatic check_cnt(input int c, input logic [7:0] exp);
      cnt_sel = 2'(c);
      #1;
      chk($sformatf("cnt%0d", c), cnt_out, exp);
   endtask

   task automatic check_cnt_model();
      for (int c = 0; c < 4; c++) check_cnt(c, m_cnt[c]);
      cnt_sel = 2'd0;
   endtask

   task automatic check_log(input string tag);
      chk({tag, "_len"}, dlog.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < dlog.size(); i++) begin
         chk($sformatf("%s_ch%0d", tag, i), dlog[i], exp_q[i]);
      end
      dlog.delete();
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      en_mask   = 4'b1111;
      out_ready = 4'b1111;
      cnt_sel   = 2'd0;
      cnt_clr   = 1'b0;
      m_ptr     = 2'd0;
      for (int c = 0; c < 4; c++) m_cnt[c] = 8'd0;

      // Reset state
      @(negedge clk);
      #1;
      chk("rst_out_valid", out_valid, 4'b0000);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_sel", sel, 2'd0);
      chk("rst_in_ready", in_ready, 1'b0);
      for (int c = 0; c < 4; c++) check_cnt(c, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Full mask, all ready: eight words stream one per cycle across 0..3 twice
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h10 + 8'(i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      tick();
      exp_q = {0, 1, 2, 3, 0, 1, 2, 3};
      check_log("stream8");
      for (int c = 0; c < 4; c++) check_cnt(c, 8'd2);
      @(negedge clk);

      // Sparse mask 1010 alternates between channels 1 and 3
      en_mask = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h20 + 8'(i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      tick();
      exp_q = {1, 3, 1, 3};
      check_log("mask1010");

      // Channel 2 stalled for 5 cycles, then released
      en_mask   = 4'b0100;
      out_ready = 4'b1011;
      in_valid  = 1'b1;
      in_data   = 8'hA5;
      tick();
      in_data = 8'h5A;
      for (int i = 0; i < 5; i++) tick();
      in_valid  = 1'b0;
      out_ready = 4'b1111;
      tick();
      tick();
      exp_q = {2};
      check_log("stall_ch2");
      check_cnt(2, 8'd3);
      @(negedge clk);

      // Held word on channel 1 survives en_mask dropping to 0000
      en_mask   = 4'b0010;
      out_ready = 4'b0000;
      in_valid  = 1'b1;
      in_data   = 8'h3C;
      tick();
      en_mask = 4'b0000;
      in_data = 8'h77;
      tick();
      tick();
      out_ready = 4'b1111;
      tick();
      tick();
      tick();
      in_valid = 1'b0;
      exp_q = {1};
      check_log("mask_off");

      // Counter wrap on channel 0, then clear colliding with a delivery
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      for (int c = 0; c < 4; c++) check_cnt(c, 8'd0);
      @(negedge clk);
      en_mask = 4'b0001;
      for (int i = 0; i < 256; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("wrap_deliveries", dlog.size(), 256);
      dlog.delete();
      check_cnt(0, 8'd0);
      @(negedge clk);
      en_mask  = 4'b0010;
      in_valid = 1'b1;
      in_data  = 8'hC1;
      tick();
      in_valid = 1'b0;
      tick();
      check_cnt(1, 8'd1);
      @(negedge clk);
      en_mask  = 4'b0001;
      in_valid = 1'b1;
      in_data  = 8'hC0;
      tick();
      in_valid = 1'b0;
      cnt_clr  = 1'b1;
      tick();
      cnt_clr = 1'b0;
      tick();
      exp_q = {1, 0};
      check_log("clr_collide");
      for (int c = 0; c < 4; c++) check_cnt(c, 8'd0);
      @(negedge clk);

      // Reset while FULL discards the word; next accept goes to channel 0
      en_mask   = 4'b1111;
      out_ready = 4'b0000;
      in_valid  = 1'b1;
      in_data   = 8'h99;
      tick();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 4'b0000);
      chk("mid_rst_in_ready", in_ready, 1'b0);
      chk("mid_rst_out_data", out_data, 8'h00);
      chk("mid_rst_sel", sel, 2'd0);
      sb.delete();
      m_ptr = 2'd0;
      for (int c = 0; c < 4; c++) m_cnt[c] = 8'd0;
      check_cnt_model();
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 4'b1111;
      in_valid  = 1'b1;
      in_data   = 8'h42;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      exp_q = {0};
      check_log("post_rst");
      check_cnt(0, 8'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
